// File: rtl/ras_checkpoint_controller.sv
// RAS checkpoint tracker between IF and EX.
// Holds {tos, valid_count, is_return} per in-flight prediction and replays it on mispredict.
module ras_checkpoint_controller #(
    parameter int NUM_CKPT     = 4,
    parameter int RAS_DEPTH    = 8,
    parameter int RAS_PTR_BITS = $clog2(RAS_DEPTH),
    parameter int TAG_BITS     = $clog2(NUM_CKPT)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_stall,
    input  logic                    i_alloc_valid,
    input  logic                    i_alloc_is_return,
    input  logic [RAS_PTR_BITS-1:0] i_alloc_tos,
    input  logic [RAS_PTR_BITS:0]   i_alloc_valid_count,
    output logic                    o_alloc_ready,
    output logic [TAG_BITS-1:0]     o_alloc_tag,
    input  logic                    i_resolve_valid,
    input  logic [TAG_BITS-1:0]     i_resolve_tag,
    input  logic                    i_resolve_mispredict,
    input  logic                    i_flush,
    output logic                    o_restore_valid,
    output logic [RAS_PTR_BITS-1:0] o_restore_tos,
    output logic [RAS_PTR_BITS:0]   o_restore_valid_count,
    output logic                    o_pop_after_restore,
    output logic [TAG_BITS:0]       o_occupancy,
    output logic                    o_protocol_error
);

    localparam int CNT_W = TAG_BITS + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_CKPT);
    localparam logic [TAG_BITS-1:0] PTR_ONE = TAG_BITS'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        IDLE,
        RESTORE
    } state_t;

    state_t state;

    logic [TAG_BITS-1:0] head;
    logic [TAG_BITS-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [RAS_PTR_BITS-1:0] ent_tos [NUM_CKPT];
    logic [RAS_PTR_BITS:0] ent_vc [NUM_CKPT];
    logic [NUM_CKPT-1:0] ent_ret;

    logic alloc_fire;
    logic resolve_ok;
    logic resolve_bad;
    logic mispredict;

    // Handshake and resolve qualification, all from current state.
    always_comb begin
        o_alloc_ready = (state == IDLE) && (count != FULL);
        o_alloc_tag = tail;
        o_occupancy = count;
        alloc_fire = i_alloc_valid && o_alloc_ready && !i_stall;
        resolve_ok = (state == IDLE) && i_resolve_valid
            && (count != '0) && (i_resolve_tag == head);
        resolve_bad = (state == IDLE) && i_resolve_valid && !resolve_ok;
        mispredict = resolve_ok && i_resolve_mispredict;
    end

    // Checkpoint storage; an entry is only live once tail moves past it.
    always_ff @(posedge i_clk) begin
        if (alloc_fire) begin
            ent_tos[tail] <= i_alloc_tos;
            ent_vc[tail] <= i_alloc_valid_count;
            ent_ret[tail] <= i_alloc_is_return;
        end
    end

    // Control FSM: FIFO pointers, restore pulse and sticky error.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            head <= '0;
            tail <= '0;
            count <= '0;
            o_restore_valid <= 1'b0;
            o_restore_tos <= '0;
            o_restore_valid_count <= '0;
            o_pop_after_restore <= 1'b0;
            o_protocol_error <= 1'b0;
        end else if (i_flush) begin
            state <= IDLE;
            head <= '0;
            tail <= '0;
            count <= '0;
            o_restore_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (resolve_bad) begin
                        o_protocol_error <= 1'b1;
                    end
                    if (mispredict) begin
                        o_restore_valid <= 1'b1;
                        o_restore_tos <= ent_tos[head];
                        o_restore_valid_count <= ent_vc[head];
                        o_pop_after_restore <= ent_ret[head];
                        head <= '0;
                        tail <= '0;
                        count <= '0;
                        state <= RESTORE;
                    end else begin
                        o_restore_valid <= 1'b0;
                        if (alloc_fire) begin
                            tail <= tail + PTR_ONE;
                        end
                        if (resolve_ok) begin
                            head <= head + PTR_ONE;
                        end
                        if (alloc_fire && !resolve_ok) begin
                            count <= count + CNT_ONE;
                        end else if (!alloc_fire && resolve_ok) begin
                            count <= count - CNT_ONE;
                        end
                    end
                end
                RESTORE: begin
                    o_restore_valid <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    o_restore_valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ras_checkpoint_controller.sv
// Directed bench for ras_checkpoint_controller.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
module tb_ras_checkpoint_controller;

    logic clk = 1'b0;
    logic rst;
    logic stall;
    logic alloc_valid;
    logic alloc_is_return;
    logic [2:0] alloc_tos;
    logic [3:0] alloc_vc;
    logic alloc_ready;
    logic [1:0] alloc_tag;
    logic resolve_valid;
    logic [1:0] resolve_tag;
    logic resolve_mispredict;
    logic flush;
    logic restore_valid;
    logic [2:0] restore_tos;
    logic [3:0] restore_vc;
    logic pop_after_restore;
    logic [2:0] occupancy;
    logic protocol_error;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ras_checkpoint_controller dut (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .i_stall               (stall),
        .i_alloc_valid         (alloc_valid),
        .i_alloc_is_return     (alloc_is_return),
        .i_alloc_tos           (alloc_tos),
        .i_alloc_valid_count   (alloc_vc),
        .o_alloc_ready         (alloc_ready),
        .o_alloc_tag           (alloc_tag),
        .i_resolve_valid       (resolve_valid),
        .i_resolve_tag         (resolve_tag),
        .i_resolve_mispredict  (resolve_mispredict),
        .i_flush               (flush),
        .o_restore_valid       (restore_valid),
        .o_restore_tos         (restore_tos),
        .o_restore_valid_count (restore_vc),
        .o_pop_after_restore   (pop_after_restore),
        .o_occupancy           (occupancy),
        .o_protocol_error      (protocol_error)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        stall = 1'b0;
        alloc_valid = 1'b0;
        alloc_is_return = 1'b0;
        alloc_tos = '0;
        alloc_vc = '0;
        resolve_valid = 1'b0;
        resolve_tag = '0;
        resolve_mispredict = 1'b0;
        flush = 1'b0;
    endtask

    task automatic alloc(input int tos, input int vc, input logic ret);
        alloc_valid = 1'b1;
        alloc_tos = 3'(tos);
        alloc_vc = 4'(vc);
        alloc_is_return = ret;
    endtask

    task automatic resolve(input int tag, input logic mis);
        resolve_valid = 1'b1;
        resolve_tag = 2'(tag);
        resolve_mispredict = mis;
    endtask

    initial begin
        quiet();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_occ", occupancy, 0);
        check("rst_ready", alloc_ready, 1);
        check("rst_restore", restore_valid, 0);
        check("rst_err", protocol_error, 0);
        check("rst_tag", alloc_tag, 0);

        // Fill the FIFO with tos 1..4.
        for (int i = 0; i < 4; i++) begin
            alloc(i + 1, i + 1, 1'b0);
            check($sformatf("fill_tag%0d", i), alloc_tag, i);
            tick();
        end
        quiet();
        check("full_occ", occupancy, 4);
        check("full_ready", alloc_ready, 0);

        // Full: alloc is not ready so only the resolve of tag 0 takes effect.
        alloc(7, 7, 1'b0);
        resolve(0, 1'b0);
        tick();
        quiet();
        check("full_drop_occ", occupancy, 3);
        check("wrap_tag", alloc_tag, 0);

        // Refill through the wrapped tail.
        alloc(7, 7, 1'b0);
        tick();
        quiet();
        check("wrap_occ", occupancy, 4);
        check("wrap_tag1", alloc_tag, 1);

        resolve(1, 1'b0);
        tick();
        quiet();
        check("ret1_occ", occupancy, 3);

        // Alloc tag1 {5,6,ret} with correct resolve of tag2: count holds.
        alloc(5, 6, 1'b1);
        resolve(2, 1'b0);
        tick();
        quiet();
        check("same_cyc_occ", occupancy, 3);
        check("same_cyc_tag", alloc_tag, 2);

        resolve(3, 1'b0);
        tick();
        resolve(0, 1'b0);
        tick();
        quiet();
        check("drain_occ", occupancy, 1);

        // Mispredict on tag1 with a same-cycle alloc that must be dropped.
        resolve(1, 1'b1);
        alloc(2, 2, 1'b0);
        tick();
        quiet();
        check("mis_valid", restore_valid, 1);
        check("mis_tos", restore_tos, 5);
        check("mis_vc", restore_vc, 6);
        check("mis_pop", pop_after_restore, 1);
        check("mis_occ", occupancy, 0);
        check("mis_ready", alloc_ready, 0);
        resolve(0, 1'b0);
        tick();
        quiet();
        check("mis_pulse_end", restore_valid, 0);
        check("mis_hold_tos", restore_tos, 5);
        check("mis_ready_back", alloc_ready, 1);
        check("mis_resolve_noerr", protocol_error, 0);
        check("mis_tag_reset", alloc_tag, 0);

        // Mispredict plus flush: no restore pulse.
        alloc(2, 3, 1'b0);
        tick();
        alloc(3, 4, 1'b0);
        tick();
        quiet();
        check("pre_flush_occ", occupancy, 2);
        resolve(0, 1'b1);
        flush = 1'b1;
        tick();
        quiet();
        check("flush_valid", restore_valid, 0);
        check("flush_occ", occupancy, 0);
        check("flush_ready", alloc_ready, 1);
        tick();
        check("flush_valid2", restore_valid, 0);

        // Out-of-order resolve.
        alloc(1, 1, 1'b0);
        tick();
        alloc(2, 2, 1'b0);
        tick();
        quiet();
        resolve(2, 1'b0);
        tick();
        quiet();
        check("ooo_occ", occupancy, 2);
        check("ooo_err", protocol_error, 1);

        // Stall blocks allocation but not the resolve.
        stall = 1'b1;
        alloc(4, 4, 1'b0);
        resolve(0, 1'b0);
        tick();
        quiet();
        check("stall_occ", occupancy, 1);
        check("stall_tag", alloc_tag, 2);
        check("err_sticky", protocol_error, 1);

        // Reset clears the sticky error.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_err", protocol_error, 0);
        check("rst2_occ", occupancy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
